// File: rtl/adc_sample_scheduler_if.sv
// Bundle of client request/response lines and ADC driver handshake for adc_sample_scheduler.
// master = scheduler side, slave = clients plus driver.
interface adc_sample_scheduler_if;
    logic [3:0]  req;
    logic [11:0] req_ch;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [11:0] rsp_data;
    logic [2:0]  rsp_ch;
    logic        rsp_err;
    logic [7:0]  err_cnt;
    logic        busy;
    logic        adc_start;
    logic [2:0]  adc_ch;
    logic        adc_done;
    logic [15:0] adc_data;

    modport master (
        input  req, req_ch, adc_done, adc_data,
        output gnt, rsp_valid, rsp_data, rsp_ch, rsp_err, err_cnt, busy, adc_start, adc_ch
    );

    modport slave (
        output req, req_ch, adc_done, adc_data,
        input  gnt, rsp_valid, rsp_data, rsp_ch, rsp_err, err_cnt, busy, adc_start, adc_ch
    );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Round-robin arbiter placing single-channel conversion requests onto one shared ADC driver,
// with a WAIT watchdog and an enforced idle gap after every response. All outputs registered.
module adc_sample_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2000,
    parameter int GAP     = 4
) (
    input logic                    clk_in,
    input logic                    reset,
    adc_sample_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       ch_q, ch_d;
    logic [15:0]      timer_q, timer_d;
    logic [7:0]       gap_q, gap_d;
    logic [11:0]      data_q, data_d;
    logic             err_q, err_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             start_q, start_d;
    logic [3:0]       rsp_valid_q, rsp_valid_d;
    logic [11:0]      rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_ch_q, rsp_ch_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;

    // Upper frame bits carry driver framing and are deliberately dropped.
    logic unused_adc_hi;
    assign unused_adc_hi = ^bus.adc_data[15:12];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        data_d      = data_q;
        err_d       = err_q;
        gnt_d       = '0;
        start_d     = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_ch_d    = rsp_ch_q;
        rsp_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        found       = 1'b0;
        sel         = '0;
        cand        = '0;

        // Search starts just past the last winner so a held request cannot starve others.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d   = sel;
                    ptr_d   = sel;
                    ch_d    = bus.req_ch[int'(sel) * 3 +: 3];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gnt_d   = 4'b0001 << idx_q;
                start_d = 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.adc_done) begin
                    data_d  = bus.adc_data[11:0];
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == 16'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESP: begin
                rsp_valid_d = 4'b0001 << idx_q;
                rsp_data_d  = data_q;
                rsp_ch_d    = ch_q;
                rsp_err_d   = err_q;
                if (err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == 8'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDX_W'(NREQ - 1);
            idx_q       <= '0;
            ch_q        <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            gnt_q       <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_ch_q    <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            err_q       <= err_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.adc_start = start_q;
    assign bus.adc_ch    = ch_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ch    = rsp_ch_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Arbitrates single-channel conversion requests from up to four client blocks (pixel frame sequencer, housekeeping monitors) onto the one shared ADC128S022 serial driver. It grants one requester at a time in round-robin order, issues the driver start pulse with the selected mux channel, and routes the 12-bit result back to the granted requester. A watchdog recovers from a driver that never completes. Sits between the frame-control FSMs and the ADC128S022 driver instance.

## Interface
- NREQ, 4, number of requesters (fixed at 4 in this revision)
- TIMEOUT, 2000, clk_in cycles allowed in WAIT before abort (1..65535)
- GAP, 4, idle cycles enforced after each response before next grant (1..255)

- clk_in  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- req  in  4  level request per requester
- req_ch  in  12  requested ADC channel, 3 bits per requester (req_ch[3i+2:3i])
- gnt  out  4  one-hot, 1-cycle pulse: request i accepted
- rsp_valid  out  4  one-hot, 1-cycle pulse: result for requester i
- rsp_data  out  12  conversion result, valid with rsp_valid
- rsp_ch  out  3  channel of the returned result
- rsp_err  out  1  high with rsp_valid when conversion timed out
- err_cnt  out  8  saturating count of timeouts since reset
- busy  out  1  high in every state except IDLE
- adc_start  out  1  1-cycle start pulse to driver
- adc_ch  out  3  channel to driver, held stable ISSUE through WAIT
- adc_done  in  1  driver completion pulse (1 cycle)
- adc_data  in  16  driver frame; result is adc_data[11:0]

## Operation
- Reset values: all outputs 0; state IDLE; RR pointer = 3 (requester 0 highest priority first); timers 0.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE: if any req bit set, select first set bit searching from pointer+1 mod 4 upward; latch index and its req_ch; pointer <= index; go ISSUE. Else stay.
- ISSUE (1 cycle): gnt[index]=1, adc_start=1, adc_ch=latched channel; go WAIT, clear timer.
- WAIT: timer increments each cycle. adc_done=1 -> latch adc_data[11:0], go RESP with err=0. Else timer reaches TIMEOUT-1 -> go RESP with err=1, data 0. adc_done and timeout in the same cycle: done wins, err=0.
- RESP (1 cycle): rsp_valid[index]=1, rsp_data, rsp_ch, rsp_err driven; if err, err_cnt += 1 saturating at 255. Go GAP.
- GAP: count GAP cycles, then IDLE. rsp_data/rsp_ch hold last value until next RESP; rsp_err returns 0 after RESP.
- adc_done outside WAIT ignored. req changes after latch do not alter the in-flight conversion; req dropped before selection is simply not served.
- A requester holding req high after its response is re-requesting; round-robin guarantees other pending requesters are served first.
- Reset asserted mid-operation: immediate return to reset values; late adc_done after release ignored (arrives in IDLE).

## Timing
- Outputs registered. req sampled at edge E0 in IDLE -> state ISSUE after E0; gnt/adc_start high for the cycle after E1 (ISSUE registered outputs): latency req-to-start = 2 edges.
- adc_done sampled at edge Ed -> rsp_valid high for exactly one cycle starting one edge later.
- Minimum spacing between consecutive adc_start pulses: 1 (ISSUE) + WAIT length + 1 (RESP) + GAP + 1 (IDLE) cycles.
- Timeout: WAIT occupies exactly TIMEOUT cycles when adc_done never arrives.

## Test plan
- Single request: req=4'b0001, req_ch[2:0]=5; driver returns adc_done 40 cycles after start with adc_data=16'h0ABC -> one gnt[0], adc_ch=5, rsp_valid[0] with rsp_data=12'hABC, rsp_ch=5, rsp_err=0.
- Fairness: req=4'b1111 held constantly -> grants in order 0,1,2,3,0,1; no requester granted twice before all others.
- Timeout: adc_done never asserted, TIMEOUT=2000 -> rsp_valid after 2000 WAIT cycles with rsp_err=1, rsp_data=0, err_cnt=1; 300 timeouts -> err_cnt=255.
- Done/timeout collision: adc_done on last WAIT cycle -> rsp_err=0, data returned, err_cnt unchanged.
- Stray done: adc_done pulses in IDLE and GAP -> no rsp_valid, state unaffected.
- Reset mid-WAIT: assert reset during WAIT, release, then adc_done -> all outputs 0, no rsp_valid; next req=4'b0100 granted to requester 0-first order (pointer=3) -> gnt[2].
